pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_pkg.sv | 13 +
 rtl/pulse_gen_ch.sv | 112 +++++++++++
 rtl/pulse_train_gen.sv | 43 ++++
 tb/tb_pulse_train_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse train generator: channel FSM state
// encoding and the default length-field width.
package pulse_pkg;

  localparam int unsigned CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pulse_state_e;

endpackage

// File: rtl/pulse_gen_ch.sv
// Single pulse channel: on start, latches high/low/burst lengths and emits
// a train of high_len-cycle pulses separated by low_len cycles.
// Ports:
//   clk, rst_n                  clock, async active-low reset
//   start, stop                 start request / abort request
//   high_len, low_len, burst_len  lengths in cycles (burst_len 0 = continuous)
//   pulse_out                   registered pulse output
//   busy                        high in HIGH or LOW
//   done                        one-cycle strobe at natural end of a burst
module pulse_gen_ch
  import pulse_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] high_len,
  input  logic [CNT_W-1:0] low_len,
  input  logic [CNT_W-1:0] burst_len,
  output logic             pulse_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  pulse_state_e     state;
  logic [CNT_W-1:0] cnt;     // cycles remaining in current phase, minus one
  logic [CNT_W-1:0] rem;     // pulses remaining including the current one
  logic [CNT_W-1:0] high_q;
  logic [CNT_W-1:0] low_q;   // already forced to at least 1
  logic             cont_q;  // continuous mode (burst_len was 0)

  // Channel FSM with registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      rem       <= '0;
      high_q    <= '0;
      low_q     <= '0;
      cont_q    <= 1'b0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start && !stop) begin
            high_q <= high_len;
            low_q  <= (low_len == '0) ? ONE : low_len;
            cont_q <= (burst_len == '0);
            rem    <= burst_len;
            if (high_len == '0) begin
              // Zero-width pulse: finish immediately without leaving IDLE
              done <= 1'b1;
            end else begin
              state     <= ST_HIGH;
              pulse_out <= 1'b1;
              busy      <= 1'b1;
              cnt       <= high_len - ONE;
            end
          end
        end
        ST_HIGH: begin
          if (stop) begin
            state     <= ST_IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            cnt       <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else if (cont_q || (rem > ONE)) begin
            state     <= ST_LOW;
            pulse_out <= 1'b0;
            cnt       <= low_q - ONE;
            if (!cont_q) rem <= rem - ONE;
          end else begin
            state     <= ST_IDLE;
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            rem       <= '0;
          end
        end
        ST_LOW: begin
          if (stop) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (cnt != '0) begin
            cnt <= cnt - ONE;
          end else begin
            state     <= ST_HIGH;
            pulse_out <= 1'b1;
            cnt       <= high_q - ONE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          pulse_out <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pulse_train_gen.sv
// Multi-channel pulse train generator: CH independent pulse_gen_ch
// instances fed from flattened per-channel length buses.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start, stop       per-channel start / abort requests
//   high_len, low_len, burst_len  per-channel fields, channel i at [i*CNT_W +: CNT_W]
//   pulse_out, busy, done         per-channel outputs
module pulse_train_gen
  import pulse_pkg::*;
#(
  parameter int unsigned CH    = 4,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH-1:0]       start,
  input  logic [CH-1:0]       stop,
  input  logic [CH*CNT_W-1:0] high_len,
  input  logic [CH*CNT_W-1:0] low_len,
  input  logic [CH*CNT_W-1:0] burst_len,
  output logic [CH-1:0]       pulse_out,
  output logic [CH-1:0]       busy,
  output logic [CH-1:0]       done
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    pulse_gen_ch #(
      .CNT_W(CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start[i]),
      .stop     (stop[i]),
      .high_len (high_len[i*CNT_W +: CNT_W]),
      .low_len  (low_len[i*CNT_W +: CNT_W]),
      .burst_len(burst_len[i*CNT_W +: CNT_W]),
      .pulse_out(pulse_out[i]),
      .busy     (busy[i]),
      .done     (done[i])
    );
  end

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed testbench for pulse_train_gen (CH=4, CNT_W=8).
module tb_pulse_train_gen;

  logic        clk;
  logic        rst_n;
  logic [3:0]  start;
  logic [3:0]  stop;
  logic [31:0] high_len;
  logic [31:0] low_len;
  logic [31:0] burst_len;
  logic [3:0]  pulse_out;
  logic [3:0]  busy;
  logic [3:0]  done;

  pulse_train_gen #(.CH(4), .CNT_W(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .high_len (high_len),
    .low_len  (low_len),
    .burst_len(burst_len),
    .pulse_out(pulse_out),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  start;
    logic [3:0]  stop;
    logic [31:0] hl;
    logic [31:0] ll;
    logic [31:0] bl;
    logic [3:0]  pulse;
    logic [3:0]  busy;
    logic [3:0]  done;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] cfg_hl, cfg_ll, cfg_bl;
  int          n_tests = 0;
  int          n_fail  = 0;

  function automatic void set_cfg(int ch, logic [7:0] h, logic [7:0] l, logic [7:0] b);
    cfg_hl[ch*8 +: 8] = h;
    cfg_ll[ch*8 +: 8] = l;
    cfg_bl[ch*8 +: 8] = b;
  endfunction

  function automatic void add(string nm, logic [3:0] st, logic [3:0] sp,
                              logic [3:0] p, logic [3:0] b, logic [3:0] d);
    vec_t v;
    v.name  = nm;
    v.start = st;
    v.stop  = sp;
    v.hl    = cfg_hl;
    v.ll    = cfg_ll;
    v.bl    = cfg_bl;
    v.pulse = p;
    v.busy  = b;
    v.done  = d;
    vecs.push_back(v);
  endfunction

  task automatic chk(string nm, int row, logic [3:0] got, logic [3:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s row %0d: got %b, expected %b", nm, row, got, want);
    end
  endtask

  task automatic chk3(string nm, int row, logic [3:0] p, logic [3:0] b, logic [3:0] d);
    chk({nm, ".pulse_out"}, row, pulse_out, p);
    chk({nm, ".busy"},      row, busy,      b);
    chk({nm, ".done"},      row, done,      d);
  endtask

  initial begin
    rst_n = 1'b0; start = '0; stop = '0;
    high_len = '0; low_len = '0; burst_len = '0;
    cfg_hl = '0; cfg_ll = '0; cfg_bl = '0;

    // ch0: 3 high, 2 low, 2 pulses
    set_cfg(0, 8'd3, 8'd2, 8'd2);
    add("burst0", 4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    add("burst0", 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    add("burst0", 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    add("burst0", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add("burst0", 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    add("burst0", 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    add("burst0", 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    add("burst0", 4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0000);
    add("burst0", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
    add("burst0", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // ch1: continuous 1-high/1-low square wave, then stop
    set_cfg(1, 8'd1, 8'd0, 8'd0);
    add("square1", 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    add("square1", 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    add("square1", 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    add("square1", 4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0000);
    add("square1", 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b0000);
    add("square1", 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
    add("square1", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // ch2: start+stop together, then zero-width pulse
    set_cfg(2, 8'd2, 8'd1, 8'd1);
    add("ststop2", 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
    add("ststop2", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
    set_cfg(2, 8'd0, 8'd2, 8'd1);
    add("zero2",   4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0100);
    add("zero2",   4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // ch3: restart mid-burst with different lengths is ignored
    set_cfg(3, 8'd2, 8'd3, 8'd2);
    add("restart3", 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    set_cfg(3, 8'd5, 8'd1, 8'd1);
    add("restart3", 4'b1000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    add("restart3", 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    add("restart3", 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    add("restart3", 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0000);
    add("restart3", 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    add("restart3", 4'b0000, 4'b0000, 4'b1000, 4'b1000, 4'b0000);
    add("restart3", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000);
    add("restart3", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // all four channels started together, distinct lengths
    set_cfg(0, 8'd1, 8'd1, 8'd1);
    set_cfg(1, 8'd2, 8'd1, 8'd2);
    set_cfg(2, 8'd3, 8'd0, 8'd1);
    set_cfg(3, 8'd1, 8'd2, 8'd2);
    add("all4", 4'b1111, 4'b0000, 4'b1111, 4'b1111, 4'b0000);
    add("all4", 4'b0000, 4'b0000, 4'b0110, 4'b1110, 4'b0001);
    add("all4", 4'b0000, 4'b0000, 4'b0100, 4'b1110, 4'b0000);
    add("all4", 4'b0000, 4'b0000, 4'b1010, 4'b1010, 4'b0100);
    add("all4", 4'b0000, 4'b0000, 4'b0010, 4'b0010, 4'b1000);
    add("all4", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
    add("all4", 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);

    // reset state, before any clock edge
    #2;
    chk3("reset", -1, 4'b0000, 4'b0000, 4'b0000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      start     = vecs[i].start;
      stop      = vecs[i].stop;
      high_len  = vecs[i].hl;
      low_len   = vecs[i].ll;
      burst_len = vecs[i].bl;
      @(posedge clk);
      #1;
      chk3(vecs[i].name, i, vecs[i].pulse, vecs[i].busy, vecs[i].done);
    end

    // asynchronous reset in the middle of a HIGH phase
    high_len = 32'h0000_0005; low_len = 32'h0000_0001; burst_len = 32'h0000_0001;
    start = 4'b0001;
    @(posedge clk);
    #1;
    start = '0;
    chk3("arst_pre", 0, 4'b0001, 4'b0001, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk3("arst_now", 0, 4'b0000, 4'b0000, 4'b0000);
    @(posedge clk);
    #1;
    chk3("arst_hold", 0, 4'b0000, 4'b0000, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      #1;
      chk3("arst_post", k, 4'b0000, 4'b0000, 4'b0000);
    end

    // first start after reset release is honoured
    high_len = 32'h0000_0001;
    start = 4'b0001;
    @(posedge clk);
    #1;
    start = '0;
    chk3("post_rst_start", 0, 4'b0001, 4'b0001, 4'b0000);
    @(posedge clk);
    #1;
    chk3("post_rst_start", 1, 4'b0000, 4'b0000, 4'b0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
